// File: rtl/exec_commit_stage.sv
// exec_commit_stage
// Execute-to-writeback stage sitting directly behind the ALU. Each ALU result
// is checked against the ARM condition field using the architectural CPSR.
// Flag updates are committed at the accepting edge. Failed ops and compare
// ops are consumed without a writeback. Register writes that commit are
// buffered in a small FIFO that feeds the register-file write port.
//
// Ports:
//   clk, reset (async, active-low), flush (sync; clears FIFO, keeps CPSR)
//   in_valid/in_ready      : ALU side
//   in_cond, in_op, in_set_flags, in_rd, in_result, in_flags : ALU payload
//   out_valid/out_ready    : register-file write side
//   out_rd, out_data       : head FIFO entry, or 0 when the FIFO is empty
//   cpsr                   : architectural flags {V,N,C,Z}
//   stat_commit, stat_squash : only present when COMMIT_STATS_EN is defined
//
// Flag bit order follows the ALU: [0]=Z, [1]=C, [2]=N, [3]=V.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. Once valid is raised, the payload is held stable until
// that transfer. in_ready depends only on registered state. flush has
// priority and blocks every transfer in its cycle.
//
// Optional feature macro: COMMIT_STATS_EN (saturating commit/squash counters).
module exec_commit_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [4:0]        in_op,
  input  logic              in_set_flags,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        cpsr
`ifdef COMMIT_STATS_EN
  ,
  output logic [15:0]       stat_commit,
  output logic [15:0]       stat_squash
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [RD_W-1:0]   mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic z, c, n, v;
  logic pass, is_cmp, accept, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign z = cpsr[0];
  assign c = cpsr[1];
  assign n = cpsr[2];
  assign v = cpsr[3];

  // Condition evaluation uses the registered CPSR only. A flag update from
  // the op accepted in this cycle becomes visible to the next op.
  always_comb begin
    pass = 1'b0;
    case (in_cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c && !z;
      4'b1001: pass = !c || z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z && (n == v);
      4'b1101: pass = z || (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // TST/TEQ/CMP/CMN occupy 01000..01011. They always set flags and never
  // write back.
  assign is_cmp    = (in_op[4:2] == 3'b010);
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready && !flush;
  assign push      = accept && pass && !is_cmp;
  assign pop       = out_valid && out_ready;

  assign out_rd    = out_valid ? mem_rd[rd_ptr]   : '0;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpsr   <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      // A pop or push in the flush cycle is discarded. cpsr holds.
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept && pass && (in_set_flags || is_cmp))
        cpsr <= in_flags;
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset. Empty slots are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_result;
    end
  end

`ifdef COMMIT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_commit <= '0;
      stat_squash <= '0;
    end else if (accept) begin
      if (pass && stat_commit != 16'hFFFF)
        stat_commit <= stat_commit + 16'd1;
      else if (!pass && stat_squash != 16'hFFFF)
        stat_squash <= stat_squash + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_commit_stage.sv
module tb_exec_commit_stage;

  localparam int DATA_W = 32;
  localparam int RD_W   = 4;
  localparam int DEPTH  = 2;
  localparam int W      = RD_W + DATA_W;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cond;
  logic [4:0]        in_op;
  logic              in_set_flags;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_result;
  logic [3:0]        in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        cpsr;
`ifdef COMMIT_STATS_EN
  logic [15:0]       stat_commit;
  logic [15:0]       stat_squash;
`endif

  exec_commit_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_op(in_op), .in_set_flags(in_set_flags),
    .in_rd(in_rd), .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .cpsr(cpsr)
`ifdef COMMIT_STATS_EN
    , .stat_commit(stat_commit), .stat_squash(stat_squash)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  logic [3:0]   m_cpsr;
  int           m_commit, m_squash;
  int           total, bad;

  // ARM conditions come in pairs: the odd code is the inverse of the even
  // one. AL (1110) gives 1, so its odd partner 1111 gives 0 (never).
  function automatic logic model_pass(input logic [3:0] cond, input logic [3:0] f);
    logic zf, cf, nf, vf, base;
    zf = f[0]; cf = f[1]; nf = f[2]; vf = f[3];
    case (cond[3:1])
      3'd0: base = zf;
      3'd1: base = cf;
      3'd2: base = nf;
      3'd3: base = vf;
      3'd4: base = cf & ~zf;
      3'd5: base = (nf == vf);
      3'd6: base = ~zf & (nf == vf);
      default: base = 1'b1;
    endcase
    return cond[0] ? ~base : base;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_cpsr   = 4'b0;
    m_commit = 0;
    m_squash = 0;
  endtask

  // One clock edge of the reference model, evaluated on the pre-edge state.
  task automatic model_step(input logic v, input logic [3:0] cond, input logic [4:0] op,
                            input logic s, input logic [RD_W-1:0] rd,
                            input logic [DATA_W-1:0] res, input logic [3:0] f,
                            input logic ordy, input logic fl);
    bit ready, ok, cmp;
    ready = (exp_q.size() < DEPTH);
    if (fl) begin
      exp_q.delete();
      return;
    end
    ok  = model_pass(cond, m_cpsr);
    cmp = (op >= 5'd8) && (op <= 5'd11);
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (v && ready) begin
      if (ok) begin
        if (m_commit < 65535) m_commit++;
        if (s || cmp) m_cpsr = f;
        if (!cmp) exp_q.push_back({rd, res});
      end else if (m_squash < 65535) begin
        m_squash++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [W-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("rnd_in_ready",  64'(in_ready),  64'(exp_q.size() < DEPTH));
    chk("rnd_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("rnd_out_rd",    64'(out_rd),    64'(head[W-1:DATA_W]));
    chk("rnd_out_data",  64'(out_data),  64'(head[DATA_W-1:0]));
    chk("rnd_cpsr",      64'(cpsr),      64'(m_cpsr));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs just after an edge, advances the model and
  // returns 1 time unit after the next rising edge.
  task automatic apply(input logic v, input logic [3:0] cond, input logic [4:0] op,
                       input logic s, input logic [RD_W-1:0] rd,
                       input logic [DATA_W-1:0] res, input logic [3:0] f,
                       input logic ordy, input logic fl);
    in_valid = v; in_cond = cond; in_op = op; in_set_flags = s;
    in_rd = rd; in_result = res; in_flags = f; out_ready = ordy; flush = fl;
    model_step(v, cond, op, s, rd, res, f, ordy, fl);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic              v;
    logic [3:0]        cond;
    logic [4:0]        op;
    logic              s;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] res;
    logic [3:0]        f;
    logic              ordy;
    logic              fl;
    logic              e_rdy;
    logic              e_ov;
    logic [RD_W-1:0]   e_rd;
    logic [DATA_W-1:0] e_data;
    logic [3:0]        e_cpsr;
  } vec_t;

  localparam logic [3:0] AL = 4'b1110, EQ = 4'b0000, NE = 4'b0001,
                         GE = 4'b1010, LT = 4'b1011, NV = 4'b1111;
  localparam logic [4:0] ADD = 5'b00100, CMP = 5'b01010, MOV = 5'b01101;

  vec_t vecs[21];

  initial begin
    // expected fields: in_ready, out_valid, out_rd, out_data, cpsr after the edge
    //         v  cond op  s  rd     res       f     ordy  fl   rdy ov rd  data  cpsr
    vecs[0]  = '{1, AL, ADD, 1, 4'd3,  32'd10,  4'b0000, 0, 0,  1, 1, 3,  10,  4'b0000};
    vecs[1]  = '{0, AL, ADD, 0, 4'd0,  32'd0,   4'b0000, 1, 0,  1, 0, 0,  0,   4'b0000};
    vecs[2]  = '{1, AL, CMP, 0, 4'd9,  32'd99,  4'b0001, 1, 0,  1, 0, 0,  0,   4'b0001};
    vecs[3]  = '{1, NE, MOV, 0, 4'd2,  32'd5,   4'b0000, 1, 0,  1, 0, 0,  0,   4'b0001};
    vecs[4]  = '{1, EQ, MOV, 0, 4'd2,  32'd5,   4'b1111, 0, 0,  1, 1, 2,  5,   4'b0001};
    vecs[5]  = '{0, AL, ADD, 0, 4'd0,  32'd0,   4'b0000, 1, 0,  1, 0, 0,  0,   4'b0001};
    // backpressure: two accepts fill the FIFO, the third is held
    vecs[6]  = '{1, AL, ADD, 0, 4'd4,  32'd100, 4'b0000, 0, 0,  1, 1, 4,  100, 4'b0001};
    vecs[7]  = '{1, AL, ADD, 0, 4'd5,  32'd200, 4'b0000, 0, 0,  0, 1, 4,  100, 4'b0001};
    vecs[8]  = '{1, AL, ADD, 0, 4'd6,  32'd300, 4'b0000, 0, 0,  0, 1, 4,  100, 4'b0001};
    vecs[9]  = '{1, AL, ADD, 0, 4'd6,  32'd300, 4'b0000, 1, 0,  1, 1, 5,  200, 4'b0001};
    vecs[10] = '{1, AL, ADD, 0, 4'd6,  32'd300, 4'b0000, 1, 0,  1, 1, 6,  300, 4'b0001};
    vecs[11] = '{0, AL, ADD, 0, 4'd0,  32'd0,   4'b0000, 1, 0,  1, 0, 0,  0,   4'b0001};
    // conditions with N=1, V=1
    vecs[12] = '{1, AL, CMP, 0, 4'd0,  32'd0,   4'b1100, 1, 0,  1, 0, 0,  0,   4'b1100};
    vecs[13] = '{1, GE, ADD, 0, 4'd7,  32'd7,   4'b0000, 0, 0,  1, 1, 7,  7,   4'b1100};
    vecs[14] = '{1, LT, ADD, 1, 4'd8,  32'd8,   4'b0011, 1, 0,  1, 0, 0,  0,   4'b1100};
    vecs[15] = '{1, NV, ADD, 1, 4'd8,  32'd8,   4'b0011, 1, 0,  1, 0, 0,  0,   4'b1100};
    // flush with two buffered entries and a presented input
    vecs[16] = '{1, AL, ADD, 0, 4'd1,  32'd11,  4'b0000, 0, 0,  1, 1, 1,  11,  4'b1100};
    vecs[17] = '{1, AL, ADD, 0, 4'd2,  32'd22,  4'b0000, 0, 0,  0, 1, 1,  11,  4'b1100};
    vecs[18] = '{1, AL, ADD, 1, 4'd3,  32'd33,  4'b0001, 1, 1,  1, 0, 0,  0,   4'b1100};
    // refill for the mid-stream reset
    vecs[19] = '{1, AL, ADD, 1, 4'd9,  32'd9,   4'b1010, 0, 0,  1, 1, 9,  9,   4'b1010};
    vecs[20] = '{1, AL, ADD, 0, 4'd10, 32'd10,  4'b0000, 0, 0,  0, 1, 9,  9,   4'b1010};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic              v, s, ordy, fl;
    logic [3:0]        cond, f;
    logic [4:0]        op;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] res;

    total = 0; bad = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cond = 4'b0; in_op = 5'b0;
    in_set_flags = 1'b0; in_rd = '0; in_result = '0; in_flags = 4'b0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_out_rd",    64'(out_rd),    64'd0);
    chk("reset_out_data",  64'(out_data),  64'd0);
    chk("reset_cpsr",      64'(cpsr),      64'd0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].v, vecs[i].cond, vecs[i].op, vecs[i].s, vecs[i].rd,
            vecs[i].res, vecs[i].f, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d_out_rd", i),    64'(out_rd),    64'(vecs[i].e_rd));
      chk($sformatf("vec%0d_out_data", i),  64'(out_data),  64'(vecs[i].e_data));
      chk($sformatf("vec%0d_cpsr", i),      64'(cpsr),      64'(vecs[i].e_cpsr));
    end

    // Asynchronous reset between edges with two entries and cpsr=1010.
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_cpsr",      64'(cpsr),      64'd0);
    chk("async_rst_out_data",  64'(out_data),  64'd0);
    chk("async_rst_out_rd",    64'(out_rd),    64'd0);
    chk("async_rst_in_ready",  64'(in_ready),  64'd1);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      cond = 4'($urandom_range(0, 15));
      op   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 11)) : 5'($urandom_range(0, 31));
      s    = 1'($urandom_range(0, 1));
      rd   = RD_W'($urandom_range(0, 15));
      res  = $urandom;
      f    = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 19) == 0);
      apply(v, cond, op, s, rd, res, f, ordy, fl);
      check_model();
    end

`ifdef COMMIT_STATS_EN
    chk("stat_commit", 64'(stat_commit), 64'(m_commit));
    chk("stat_squash", 64'(stat_squash), 64'(m_squash));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_commit_stage.md
Name: exec_commit_stage

Overview:
- Execute-to-writeback stage directly downstream of the ALU.
- Latches each ALU result with its condition code, evaluates the ARM condition against the architectural CPSR (NZCV), commits flag updates, and squashes failed or non-writing ops.
- Buffers committed register writes in a small FIFO with valid/ready handshake toward the register-file write port.
- ALU flag encoding is kept: flags[0]=Z, [1]=C, [2]=N, [3]=V.

Parameters:
DATA_W, 32, result/data width
RD_W, 4, destination register index width
DEPTH, 2, writeback FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush (branch taken); clears FIFO, keeps CPSR
in_valid  in  1  ALU output valid
in_ready  out  1  stage can accept (FIFO not full)
in_cond  in  4  ARM condition field
in_op  in  5  ALU operation code
in_set_flags  in  1  S bit
in_rd  in  RD_W  destination register
in_result  in  DATA_W  ALU result
in_flags  in  4  ALU flags {V,N,C,Z}
out_valid  out  1  writeback entry available
out_ready  in  1  regfile write accepted
out_rd  out  RD_W  head entry register index
out_data  out  DATA_W  head entry data
cpsr  out  4  architectural flags {V,N,C,Z}

Behaviour:
- Reset (reset=0, async): cpsr=0, FIFO count=0, rd/wr pointers=0, out_valid=0, out_rd=0, out_data=0.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready.
- Accept = in_valid & in_ready & ~flush.
- Condition pass, evaluated combinationally against the current cpsr:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 4'b1111 = never (0).
- Compare class: in_op 01000..01011 (TST/TEQ/CMP/CMN). These never write back and always update flags when passed.
- On accept & pass:
  - cpsr <= in_flags if in_set_flags or compare class; otherwise cpsr is unchanged.
  - Non-compare ops push {in_rd, in_result}.
- On accept & fail: no push, cpsr unchanged. The op is consumed (squash).
- CPSR is updated at the accepting edge. The next accepted op (earliest the following cycle) sees the new flags, so no same-cycle bypass exists.
- Pop when out_valid & out_ready. out_valid = (count != 0). out_rd/out_data = head entry, or 0 when empty.
- Push and pop in the same cycle: count unchanged, pointers both advance. This is legal only when count<DEPTH (push requires in_ready).
- Pointers wrap modulo DEPTH.
- Full: in_ready=0; the upstream op holds until a pop frees a slot (in_ready rises the cycle after the pop).
- flush=1 at an edge: count, pointers <= 0, out_valid=0 next cycle. Any simultaneous pop/push is discarded, the presented input is not accepted, and cpsr holds.
- Reset asserted mid-operation: all state is cleared immediately, and pending entries are lost.
- Latency: accepted pushing op appears on out_valid 1 cycle after acceptance.

Optional Feature:
Macro: COMMIT_STATS_EN
- Defined: adds outputs stat_commit[15:0] and stat_squash[15:0].
  - stat_commit increments on each accept&pass; stat_squash increments on each accept&fail.
  - Both saturate at 16'hFFFF, reset to 0, and are unaffected by flush.
  - If both events occur in one cycle, only one increments (mutually exclusive by definition).
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ADD (00100), cond=AL, S=1, rd=3, result=10, flags=4'b0000 -> one cycle later out_valid=1, out_rd=3, out_data=10; cpsr=0000.
- CMP (01010), cond=AL, flags=4'b0001 (Z), then MOV (01101) cond=NE rd=2 result=5 -> no push, cpsr=0001; next MOV cond=EQ rd=2 result=5 -> push {2,5}.
- out_ready=0, three AL ADDs back-to-back -> in_ready=0 after two accepts, the third is held; raise out_ready -> pops {rd0},{rd1}, third accepted, order preserved.
- cond GE with cpsr N=1,V=1 -> pass; cond LT -> squash; cond 4'b1111 -> squash with S=1, cpsr unchanged.
- Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, cpsr unchanged, input not accepted.
- Assert reset low mid-stream with two entries and cpsr=1010 -> immediately out_valid=0, cpsr=0000, out_data=0.
